// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared states, lamp codes and counter constants for the traffic light controller
package tl_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        NSG   = 3'd1,
        NSY   = 3'd2,
        EWG   = 3'd3,
        EWY   = 3'd4,
        FLASH = 3'd5
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam logic [7:0] CNT_MAX = 8'h99;
    localparam logic [7:0] CNT_ONE = 8'h01;

endpackage

// File: rtl/counter_8421_2b.sv
// rtl/counter_8421_2b.sv - two-digit 8421 BCD up/down counter with synchronous load and wrap at MAX
module counter_8421_2b (
    input  logic       CP,
    input  logic       CR,
    input  logic       CE,
    input  logic       UP,
    input  logic       PE,
    input  logic [7:0] D,
    input  logic [7:0] MAX,
    output logic [7:0] Q
);

    always_ff @(posedge CP) begin
        if (CR) begin
            Q <= 8'h00;
        end else if (CE) begin
            if (PE) begin
                Q <= D;
            end else if (UP) begin
                if (Q == MAX)
                    Q <= 8'h00;
                else if (Q[3:0] == 4'd9)
                    Q <= {Q[7:4] + 4'd1, 4'd0};
                else
                    Q <= {Q[7:4], Q[3:0] + 4'd1};
            end else begin
                if (Q == 8'h00)
                    Q <= MAX;
                else if (Q[3:0] == 4'd0)
                    Q <= {Q[7:4] - 4'd1, 4'd9};
                else
                    Q <= {Q[7:4], Q[3:0] - 4'd1};
            end
        end
    end

endmodule

// File: rtl/tl_lamp_decode.sv
// rtl/tl_lamp_decode.sv - combinational lamp decode from registered phase and flash_on
module tl_lamp_decode
    import tl_pkg::*;
(
    input  state_t     state,
    input  logic       flash_on,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp
);

    always_comb begin
        ns_lamp = RED;
        ew_lamp = RED;
        case (state)
            NSG:     ns_lamp = GRN;
            NSY:     ns_lamp = YEL;
            EWG:     ew_lamp = GRN;
            EWY:     ew_lamp = YEL;
            FLASH: begin
                ns_lamp = flash_on ? YEL : OFF;
                ew_lamp = flash_on ? YEL : OFF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-road phase sequencer driving an external BCD down-counter timer
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter logic [7:0] T_NSG = 8'h25,
    parameter logic [7:0] T_NSY = 8'h03,
    parameter logic [7:0] T_EWG = 8'h20,
    parameter logic [7:0] T_EWY = 8'h03
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       tick,
    input  logic       hold,
    input  logic       night,
    input  logic [7:0] cnt_q,
    output logic       cnt_ce,
    output logic       cnt_up,
    output logic       cnt_pe,
    output logic [7:0] cnt_d,
    output logic [7:0] cnt_max,
    output logic [2:0] ns_lamp,
    output logic [2:0] ew_lamp,
    output logic [2:0] phase
);

    state_t state;
    logic   flash_on;
    logic   phase_end;

    assign cnt_up    = 1'b0;
    assign cnt_max   = CNT_MAX;
    assign phase     = state;
    assign phase_end = tick && (cnt_q == CNT_ONE);

    always_ff @(posedge CP) begin
        if (CR) begin
            state    <= INIT;
            flash_on <= 1'b0;
        end else begin
            case (state)
                INIT: state <= NSG;
                NSG, NSY, EWG, EWY: begin
                    if (night) begin
                        state    <= FLASH;
                        flash_on <= 1'b1;
                    end else if (!hold && phase_end) begin
                        case (state)
                            NSG:     state <= NSY;
                            NSY:     state <= EWG;
                            EWG:     state <= EWY;
                            default: state <= NSG;
                        endcase
                    end
                end
                FLASH: begin
                    if (!night)
                        state <= INIT;
                    else if (tick)
                        flash_on <= !flash_on;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Load data always presents the following phase's duration so the reload is a single-cycle pulse.
    always_comb begin
        cnt_ce = 1'b0;
        cnt_pe = 1'b0;
        case (state)
            NSG:     cnt_d = T_NSY;
            NSY:     cnt_d = T_EWG;
            EWG:     cnt_d = T_EWY;
            default: cnt_d = T_NSG;
        endcase
        case (state)
            INIT: begin
                cnt_ce = 1'b1;
                cnt_pe = 1'b1;
            end
            NSG, NSY, EWG, EWY: begin
                if (!night && !hold && tick) begin
                    cnt_ce = 1'b1;
                    cnt_pe = phase_end;
                end
            end
            default: ;
        endcase
    end

    tl_lamp_decode u_lamp_decode (
        .state    (state),
        .flash_on (flash_on),
        .ns_lamp  (ns_lamp),
        .ew_lamp  (ew_lamp)
    );

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - directed bench for traffic_light_ctrl with an external BCD counter
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       cr = 1'b1;
    logic       tick = 1'b0;
    logic       hold = 1'b0;
    logic       night = 1'b0;
    logic [7:0] cnt_q;
    logic       cnt_ce;
    logic       cnt_up;
    logic       cnt_pe;
    logic [7:0] cnt_d;
    logic [7:0] cnt_max;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic [2:0] phase;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .T_NSG (8'h03),
        .T_NSY (8'h02),
        .T_EWG (8'h04),
        .T_EWY (8'h02)
    ) dut (
        .CP      (clk),
        .CR      (cr),
        .tick    (tick),
        .hold    (hold),
        .night   (night),
        .cnt_q   (cnt_q),
        .cnt_ce  (cnt_ce),
        .cnt_up  (cnt_up),
        .cnt_pe  (cnt_pe),
        .cnt_d   (cnt_d),
        .cnt_max (cnt_max),
        .ns_lamp (ns_lamp),
        .ew_lamp (ew_lamp),
        .phase   (phase)
    );

    counter_8421_2b u_cnt (
        .CP  (clk),
        .CR  (cr),
        .CE  (cnt_ce),
        .UP  (cnt_up),
        .PE  (cnt_pe),
        .D   (cnt_d),
        .MAX (cnt_max),
        .Q   (cnt_q)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One tick period of four cycles, tick high for the first.
    task automatic tick_pulse();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic chk_state(input string tag, input logic [7:0] q, input logic [2:0] ph,
                             input logic [2:0] ns, input logic [2:0] ew);
        chk({tag, "_q"}, cnt_q, q);
        chk({tag, "_phase"}, {5'd0, phase}, {5'd0, ph});
        chk({tag, "_ns"}, {5'd0, ns_lamp}, {5'd0, ns});
        chk({tag, "_ew"}, {5'd0, ew_lamp}, {5'd0, ew});
    endtask

    logic [7:0] exp_q  [11] = '{8'h02, 8'h01, 8'h02, 8'h01, 8'h04, 8'h03, 8'h02, 8'h01, 8'h02, 8'h01, 8'h03};
    logic [2:0] exp_ph [11] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd1};

    initial begin
        cyc();
        cyc();
        chk("reset_phase", {5'd0, phase}, 8'h00);
        chk("reset_q", cnt_q, 8'h00);

        cr = 1'b0;
        #1;
        chk("init_pe", {7'd0, cnt_pe}, 8'h01);
        chk("init_ce", {7'd0, cnt_ce}, 8'h01);
        chk("init_d", cnt_d, 8'h03);
        chk("init_ns", {5'd0, ns_lamp}, 8'h04);
        chk("init_ew", {5'd0, ew_lamp}, 8'h04);
        chk("cnt_up", {7'd0, cnt_up}, 8'h00);
        chk("cnt_max", cnt_max, 8'h99);
        cyc();
        chk_state("nsg0", 8'h03, 3'd1, 3'b001, 3'b100);

        for (int i = 0; i < 11; i++) begin
            tick_pulse();
            chk("cycle_q", cnt_q, exp_q[i]);
            chk("cycle_phase", {5'd0, phase}, {5'd0, exp_ph[i]});
            checks++;
            assert (cnt_q !== 8'h00) else begin
                failures++;
                $error("FAIL cycle_nonzero observed=%h expected=nonzero", cnt_q);
            end
        end

        // Advance to EWG with count 03, then hold.
        for (int i = 0; i < 6; i++) tick_pulse();
        chk_state("ewg03", 8'h03, 3'd3, 3'b100, 3'b001);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1;
            #1;
            chk("hold_ce", {7'd0, cnt_ce}, 8'h00);
            cyc();
            tick = 1'b0;
            cyc();
            cyc();
            cyc();
            chk_state("hold", 8'h03, 3'd3, 3'b100, 3'b001);
        end
        hold = 1'b0;
        cyc();
        tick_pulse();
        chk_state("unhold", 8'h02, 3'd3, 3'b100, 3'b001);

        for (int i = 0; i < 7; i++) tick_pulse();
        chk_state("nsy", 8'h02, 3'd2, 3'b010, 3'b100);
        night = 1'b1;
        cyc();
        chk_state("flash_entry", 8'h02, 3'd5, 3'b010, 3'b010);
        tick = 1'b1;
        #1;
        chk("flash_ce", {7'd0, cnt_ce}, 8'h00);
        chk("flash_pe", {7'd0, cnt_pe}, 8'h00);
        cyc();
        tick = 1'b0;
        cyc();
        chk_state("flash_off", 8'h02, 3'd5, 3'b000, 3'b000);
        tick_pulse();
        chk_state("flash_on2", 8'h02, 3'd5, 3'b010, 3'b010);
        night = 1'b0;
        cyc();
        chk("exit_phase", {5'd0, phase}, 8'h00);
        chk("exit_pe", {7'd0, cnt_pe}, 8'h01);
        chk("exit_d", cnt_d, 8'h03);
        cyc();
        chk_state("exit_nsg", 8'h03, 3'd1, 3'b001, 3'b100);

        tick_pulse();
        tick_pulse();
        chk_state("nsg01", 8'h01, 3'd1, 3'b001, 3'b100);
        tick = 1'b1;
        night = 1'b1;
        #1;
        chk("coinc_pe", {7'd0, cnt_pe}, 8'h00);
        chk("coinc_ce", {7'd0, cnt_ce}, 8'h00);
        cyc();
        tick = 1'b0;
        chk_state("coinc_flash", 8'h01, 3'd5, 3'b010, 3'b010);
        night = 1'b0;
        cyc();
        chk("coinc_init", {5'd0, phase}, 8'h00);
        cyc();
        chk_state("coinc_nsg", 8'h03, 3'd1, 3'b001, 3'b100);

        for (int i = 0; i < 10; i++) tick_pulse();
        chk_state("ewy01", 8'h01, 3'd4, 3'b100, 3'b010);
        cr = 1'b1;
        cyc();
        cr = 1'b0;
        #1;
        chk("midreset_phase", {5'd0, phase}, 8'h00);
        chk("midreset_ns", {5'd0, ns_lamp}, 8'h04);
        chk("midreset_ew", {5'd0, ew_lamp}, 8'h04);
        cyc();
        chk_state("midreset_nsg", 8'h03, 3'd1, 3'b001, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
- Two-road intersection sequencer. Drives the control inputs of one external 2-digit 8421 BCD counter (counter_8421_2b) used as a down-counting seconds timer, and decodes phase state into north-south and east-west lamp outputs.
- The counter's Q is shown on the seven-segment display as remaining seconds.
- Sits between the 1 Hz tick generator and the counter/display path.

Parameters:
- T_NSG, 8'h25, NS green duration, BCD, legal 01..99
- T_NSY, 8'h03, NS yellow duration, BCD, legal 01..99
- T_EWG, 8'h20, EW green duration, BCD, legal 01..99
- T_EWY, 8'h03, EW yellow duration, BCD, legal 01..99

Ports:
- CP  input  1  clock, rising edge
- CR  input  1  synchronous active-high reset
- tick  input  1  one-CP-cycle pulse, 1 Hz
- hold  input  1  level; freeze current phase and count
- night  input  1  level; flashing-yellow mode
- cnt_q  input  8  counter Q (BCD, tens in [7:4])
- cnt_ce  output  1  counter enable
- cnt_up  output  1  counter direction; constant 0 (down)
- cnt_pe  output  1  counter synchronous load
- cnt_d  output  8  counter load data (BCD)
- cnt_max  output  8  counter MAX; constant 8'h99
- ns_lamp  output  3  {red, yellow, green}
- ew_lamp  output  3  {red, yellow, green}
- phase  output  3  current state encoding

Behaviour:
- States: INIT=0, NSG=1, NSY=2, EWG=3, EWY=4, FLASH=5.
- Reset: CR sampled high at a CP edge puts state in INIT and clears flash_on.
- Outputs during INIT: ns_lamp=ew_lamp=3'b100, cnt_ce=1, cnt_pe=1, cnt_d=T_NSG.
- INIT lasts exactly one cycle, then goes to NSG, so the counter holds T_NSG on NSG's first cycle.
- A reset mid-phase or mid-FLASH behaves identically.
- Lamps:
  - NSG: ns=001, ew=100
  - NSY: ns=010, ew=100
  - EWG: ns=100, ew=001
  - EWY: ns=100, ew=010
  - FLASH: ns=ew={1'b0, flash_on, 1'b0}
- Normal phases (NSG/NSY/EWG/EWY), with hold=0 and night=0:
  - cnt_ce=tick, cnt_pe=0.
  - The counter decrements once per tick, so the display shows N..01.
- Phase end condition: tick=1 and cnt_q==8'h01.
  - Same cycle: cnt_ce=1, cnt_pe=1, cnt_d=next phase duration.
  - Next state order: NSG->NSY->EWG->EWY->NSG.
  - The counter goes from 01 directly to the next duration; 00 is never shown.
  - A phase therefore lasts exactly T ticks.
- cnt_d when cnt_pe=0: don't-care; drive next phase duration.
- hold=1 (night=0):
  - cnt_ce=0, cnt_pe=0. State, lamps and count are frozen; ticks are ignored.
  - After release, counting resumes at the next tick from the frozen value.
- night=1 (priority over hold and tick):
  - From any normal state, go to FLASH on the next cycle. flash_on=1 on entry.
  - In FLASH: cnt_ce=0, cnt_pe=0.
  - flash_on toggles on each tick; hold is ignored.
- Leaving FLASH: night=0 sampled in FLASH -> INIT (reload T_NSG), then NSG.
- Priority at one edge: CR > night > hold > tick.
- tick coincident with a night rising edge: FLASH entry wins, no load, flash_on=1.
- cnt_q of 00 in a normal state (should not occur): treat as non-terminal and let the counter wrap to cnt_max (99). Still legal; no lockup.
- Width rules: all durations are 8-bit BCD. Comparisons are on the raw 8-bit value. The controller does no arithmetic on cnt_q.
- phase equals the state encoding, registered.
- Lamps are combinational from registered state and flash_on; no glitch-prone inputs feed them.

Decomposition:
- Shared package tl_pkg:
  - state enum/localparams (INIT..FLASH)
  - lamp constants RED=3'b100, YEL=3'b010, GRN=3'b001, OFF=3'b000
  - CNT_MAX=8'h99
- One natural sub-module, tl_lamp_decode: combinational state+flash_on -> ns_lamp/ew_lamp.
- Everything else (FSM, flash_on, counter control) lives in traffic_light_ctrl.
- Bench instantiates counter_8421_2b with CP shared and CR tied to the same reset.

Test Plan:
- Setup: parameters T_NSG=8'h03, T_NSY=8'h02, T_EWG=8'h04, T_EWY=8'h02; tick every 4 cycles.
- Reset release -> one INIT cycle with cnt_pe=1, cnt_d=03 and lamps 100/100. Then NSG, cnt_q=03, ns=001, ew=100.
- Full cycle -> cnt_q sequence 03,02,01,02,01,04,03,02,01,02,01,03. Phases NSG,NSY,EWG,EWY,NSG, each lasting exactly T ticks. cnt_q never equals 00.
- hold=1 during EWG at cnt_q=03 for 10 ticks -> cnt_q stays 03, lamps ns=100, ew=001. After release, the next tick gives 02.
- night=1 during NSY -> FLASH next cycle, lamps 010/010. Toggles to 000/000 on the next tick. cnt_ce stays 0 and cnt_q is frozen. night=0 -> INIT (cnt_d=03) -> NSG.
- tick and night rising in the same cycle as cnt_q=01 in NSG -> FLASH, no cnt_pe pulse, flash_on=1.
- CR=1 for one cycle mid-EWY -> next cycle INIT with lamps 100/100. Then NSG with cnt_q=03.
